mem_arbiter: RTL and testbench

- Round-robin arbiter and burst sequencer for the single-port 8-entry matrix buffer.
- Three requesters share the buffer: 0 = host matrix load (normally writes), 1 = MMU operand fetch (reads), 2 = host writeback (reads).
- Grants one requester at a time and issues one memory beat per cycle for the whole burst.
- Returns read data one cycle after each read beat, steered to the owner.

---
 rtl/mem_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and burst sequencer for the shared single-port matrix buffer.
// First beat one cycle after a request is seen in IDLE; read data returns one cycle after each read beat.
module mem_arbiter #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2:0]      req,
  input  logic [2:0]      req_we,
  input  logic [3*AW-1:0] req_addr,
  input  logic [3*AW-1:0] req_len,
  input  logic [3*DW-1:0] wdata_in,
  output logic [2:0]      gnt,
  output logic [2:0]      beat_ack,
  output logic [2:0]      done,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  output logic [DW-1:0]   rdata,
  output logic [2:0]      rvalid
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nxt;
  logic [1:0]    owner, last_owner;
  logic [AW-1:0] addr, cnt;
  logic          we;
  logic [2:0]    arb_req;
  logic [1:0]    arb_last;
  logic [2:0]    pick;
  logic          load;

  function automatic logic [2:0] onehot(input logic [1:0] x);
    return 3'b001 << x;
  endfunction

  // Returns {found, index}; searches last+1, last+2, last (mod 3).
  function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    logic [1:0] i;
    logic [2:0] res;
    res = 3'b000;
    i   = last;
    for (int k = 0; k < 3; k++) begin
      i = (i == 2'd2) ? 2'd0 : i + 2'd1;
      if (!res[2] && r[i]) res = {1'b1, i};
    end
    return res;
  endfunction

  always_comb begin
    state_nxt = state;
    gnt       = '0;
    beat_ack  = '0;
    done      = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    load      = 1'b0;
    arb_req   = req;
    arb_last  = last_owner;
    // On the last beat the current owner is excluded and becomes the new search origin.
    if (state == BUSY) begin
      arb_req  = req & ~onehot(owner);
      arb_last = owner;
    end
    pick = rr_pick(arb_req, arb_last);
    case (state)
      IDLE: begin
        if (pick[2]) begin
          state_nxt = BUSY;
          load      = 1'b1;
        end
      end
      BUSY: begin
        gnt       = onehot(owner);
        beat_ack  = onehot(owner);
        mem_en    = 1'b1;
        mem_we    = we;
        mem_addr  = addr;
        mem_wdata = we ? wdata_in[owner*DW +: DW] : '0;
        if (cnt == '0) begin
          done = onehot(owner);
          if (pick[2]) load = 1'b1;
          else         state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 2'd0;
      last_owner <= 2'd2;
      addr       <= '0;
      cnt        <= '0;
      we         <= 1'b0;
      rvalid     <= '0;
    end else begin
      state  <= state_nxt;
      rvalid <= (state == BUSY && !we) ? onehot(owner) : 3'b000;
      if (state == BUSY) begin
        addr <= addr + AW'(1);
        cnt  <= cnt - AW'(1);
        if (cnt == '0) last_owner <= owner;
      end
      if (load) begin
        owner <= pick[1:0];
        addr  <= req_addr[pick[1:0]*AW +: AW];
        cnt   <= req_len[pick[1:0]*AW +: AW];
        we    <= req_we[pick[1:0]];
      end
    end
  end

  assign rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed cycle-by-cycle vectors for mem_arbiter plus a timed burst sequence.
module tb_mem_arbiter;
  localparam int DW = 8;
  localparam int AW = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [2:0]      req, req_we;
  logic [3*AW-1:0] req_addr, req_len;
  logic [3*DW-1:0] wdata_in;
  logic [2:0]      gnt, beat_ack, done, rvalid;
  logic            mem_en, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata, mem_rdata, rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_len(req_len), .wdata_in(wdata_in), .gnt(gnt), .beat_ack(beat_ack),
    .done(done), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .rdata(rdata), .rvalid(rvalid)
  );

  // Buffer model: unwritten entry i reads as C0+i.
  logic [DW-1:0] ram [8] = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7};
  always @(posedge clk) begin
    if (mem_en && mem_we)  ram[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
  end

  typedef struct {
    logic       rst;
    logic [2:0] req, we;
    logic [8:0] addr, len;
    logic [23:0] wd;
    logic [2:0] gnt, done;
    logic       en, mwe;
    logic [2:0] maddr;
    logic [7:0] mwd;
    logic [2:0] rv;
    logic [7:0] rd;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic [2:0] rq, input logic [2:0] w,
                     input logic [8:0] a, input logic [8:0] l, input logic [23:0] wd,
                     input logic [2:0] g, input logic [2:0] d, input logic en, input logic mwe,
                     input logic [2:0] ma, input logic [7:0] mwd, input logic [2:0] rv,
                     input logic [7:0] rd);
    vec_t v;
    v.rst = rst; v.req = rq; v.we = w; v.addr = a; v.len = l; v.wd = wd;
    v.gnt = g; v.done = d; v.en = en; v.mwe = mwe; v.maddr = ma; v.mwd = mwd;
    v.rv = rv; v.rd = rd;
    vecs.push_back(v);
  endtask

  task automatic idle(input logic [2:0] rv, input logic [7:0] rd);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rv, rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    logic [32:0] act, exp;
    int cyc, beats, done_at;

    // reset state
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // write burst: base 2, four beats
    add(1, 3'b001, 3'b001, 9'o002, 9'o003, 24'h0000A0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 3'b000, 3'b001, 9'o002, 9'o003, 24'h0000A0, 3'b001, 0, 1, 1, 3'd2, 8'hA0, 0, 0);
    add(1, 3'b000, 3'b001, 9'o002, 9'o003, 24'h0000A1, 3'b001, 0, 1, 1, 3'd3, 8'hA1, 0, 0);
    add(1, 3'b000, 3'b001, 9'o002, 9'o003, 24'h0000A2, 3'b001, 0, 1, 1, 3'd4, 8'hA2, 0, 0);
    add(1, 3'b000, 3'b001, 9'o002, 9'o003, 24'h0000A3, 3'b001, 3'b001, 1, 1, 3'd5, 8'hA3, 0, 0);
    idle(0, 0);
    // wrapping read by requester 1, write data must not leak
    add(1, 3'b010, 0, 9'o060, 9'o030, 24'h5A5A5A, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 3'b000, 0, 9'o060, 9'o030, 24'h5A5A5A, 3'b010, 0, 1, 0, 3'd6, 0, 0, 0);
    add(1, 3'b000, 0, 9'o060, 9'o030, 24'h5A5A5A, 3'b010, 0, 1, 0, 3'd7, 0, 3'b010, 8'hC6);
    add(1, 3'b000, 0, 9'o060, 9'o030, 24'h5A5A5A, 3'b010, 0, 1, 0, 3'd0, 0, 3'b010, 8'hC7);
    add(1, 3'b000, 0, 9'o060, 9'o030, 24'h5A5A5A, 3'b010, 3'b010, 1, 0, 3'd1, 0, 3'b010, 8'hC0);
    idle(3'b010, 8'hC1);
    idle(0, 0);
    // contention, all single-beat reads
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 3'b111, 0, 9'o432, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 3'b111, 0, 9'o432, 0, 0, 3'b001, 3'b001, 1, 0, 3'd2, 0, 0, 0);
    add(1, 3'b111, 0, 9'o432, 0, 0, 3'b010, 3'b010, 1, 0, 3'd3, 0, 3'b001, 8'hA0);
    add(1, 3'b111, 0, 9'o432, 0, 0, 3'b100, 3'b100, 1, 0, 3'd4, 0, 3'b010, 8'hA1);
    add(1, 3'b000, 0, 9'o432, 0, 0, 3'b001, 3'b001, 1, 0, 3'd2, 0, 3'b100, 8'hA2);
    idle(3'b001, 8'hA0);
    idle(0, 0);
    // re-request by requester 0 alone: an idle cycle between bursts
    add(1, 3'b001, 0, 0, 9'o001, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 3'b001, 0, 0, 9'o001, 0, 3'b001, 0, 1, 0, 3'd0, 0, 0, 0);
    add(1, 3'b001, 0, 0, 9'o001, 0, 3'b001, 3'b001, 1, 0, 3'd1, 0, 3'b001, 8'hC0);
    add(1, 3'b001, 0, 0, 9'o001, 0, 0, 0, 0, 0, 0, 0, 3'b001, 8'hC1);
    add(1, 3'b001, 0, 0, 9'o001, 0, 3'b001, 0, 1, 0, 3'd0, 0, 0, 0);
    add(1, 3'b001, 0, 0, 9'o001, 0, 3'b001, 3'b001, 1, 0, 3'd1, 0, 3'b001, 8'hC0);
    idle(3'b001, 8'hC1);
    idle(0, 0);
    // fairness between requesters 0 and 2 (writes)
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 3'b101, 3'b101, 9'o706, 0, 24'hE200E0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 3'b101, 3'b101, 9'o706, 0, 24'hE200E0, 3'b001, 3'b001, 1, 1, 3'd6, 8'hE0, 0, 0);
    add(1, 3'b101, 3'b101, 9'o706, 0, 24'hE200E0, 3'b100, 3'b100, 1, 1, 3'd7, 8'hE2, 0, 0);
    add(1, 3'b101, 3'b101, 9'o706, 0, 24'hE200E0, 3'b001, 3'b001, 1, 1, 3'd6, 8'hE0, 0, 0);
    add(1, 3'b000, 3'b101, 9'o706, 0, 24'hE200E0, 3'b100, 3'b100, 1, 1, 3'd7, 8'hE2, 0, 0);
    idle(0, 0);
    // short read by 0, then reset aborts a long read by 1
    add(1, 3'b001, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 3'b000, 0, 0, 0, 0, 3'b001, 3'b001, 1, 0, 3'd0, 0, 0, 0);
    add(1, 3'b010, 0, 0, 9'o070, 0, 0, 0, 0, 0, 0, 0, 3'b001, 8'hC0);
    add(1, 3'b000, 0, 0, 9'o070, 0, 3'b010, 0, 1, 0, 3'd0, 0, 0, 0);
    add(1, 3'b000, 0, 0, 9'o070, 0, 3'b010, 0, 1, 0, 3'd1, 0, 3'b010, 8'hC0);
    add(0, 3'b000, 0, 0, 9'o070, 0, 3'b010, 0, 1, 0, 3'd2, 0, 3'b010, 8'hC1);
    add(1, 3'b011, 0, 9'o035, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 3'b000, 0, 9'o035, 0, 0, 3'b001, 3'b001, 1, 0, 3'd5, 0, 0, 0);
    idle(3'b001, 8'hA3);
    idle(0, 0);

    rst_n = 1'b0; req = '0; req_we = '0; req_addr = '0; req_len = '0; wdata_in = '0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      rst_n = v.rst; req = v.req; req_we = v.we; req_addr = v.addr;
      req_len = v.len; wdata_in = v.wd;
      #3;
      act = {gnt, beat_ack, done, mem_en, mem_we, mem_addr, mem_wdata, rvalid,
             (v.rv != 0) ? rdata : 8'h00};
      exp = {v.gnt, v.gnt, v.done, v.en, v.mwe, v.maddr, v.mwd, v.rv, v.rd};
      chk($sformatf("vec%0d", i), 64'(act), 64'(exp));
      @(posedge clk);
      #1;
    end

    // timed 3-beat read burst by requester 2
    rst_n = 1'b0; req = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; req = 3'b100; req_we = '0; req_addr = 9'o100; req_len = 9'o200;
    cyc = 0;
    while (gnt != 3'b100 && cyc < 5) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    req = '0;
    chk("grant_latency", 64'(cyc), 64'd1);
    beats = 0;
    done_at = 0;
    while (gnt == 3'b100 && beats < 10) begin
      beats++;
      if (done == 3'b100) done_at = beats;
      @(posedge clk);
      #1;
    end
    chk("burst_beats", 64'(beats), 64'd3);
    chk("done_on_last", 64'(done_at), 64'd3);
    chk("gnt_after_burst", 64'(gnt), 64'd0);
    chk("rvalid_after_burst", 64'(rvalid), 64'(3'b100));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
